overlay_scheduler: RTL

Sequences the single shared sprite plotter once per frame: it draws the game background, then at most one status overlay chosen from the six status enables (hunger, bored, sick, dirty, dying, zzzs). The top-level control FSM drew only the highest-priority bubble. This block instead rotates round-robin through all active overlays, holding each for `HOLD_FRAMES` frames. It sits between the frame-tick generator and the plotter/sprite-ROM mux, and replaces per-bubble draw states.

---
 rtl/overlay_scheduler_pkg.sv | 31 +++
 rtl/overlay_scheduler_rr_next_slot.sv | 28 ++
 rtl/overlay_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/overlay_scheduler_pkg.sv
// Shared definitions for the overlay scheduler: FSM states, sprite IDs and
// overlay bit positions within enable_mask.
package overlay_scheduler_pkg;

  typedef enum logic [2:0] {
    WAIT_TICK = 3'd0,
    BG_START  = 3'd1,
    BG_WAIT   = 3'd2,
    OV_START  = 3'd3,
    OV_WAIT   = 3'd4,
    FRAME_END = 3'd5
  } state_e;

  localparam int NUM_OV = 6;

  localparam logic [2:0] SPR_BG     = 3'd0;
  localparam logic [2:0] SPR_HUNGER = 3'd1;
  localparam logic [2:0] SPR_BORED  = 3'd2;
  localparam logic [2:0] SPR_SICK   = 3'd3;
  localparam logic [2:0] SPR_DIRTY  = 3'd4;
  localparam logic [2:0] SPR_DYING  = 3'd5;
  localparam logic [2:0] SPR_ZZZS   = 3'd6;

  localparam int OV_HUNGER = 0;
  localparam int OV_BORED  = 1;
  localparam int OV_SICK   = 2;
  localparam int OV_DIRTY  = 3;
  localparam int OV_DYING  = 4;
  localparam int OV_ZZZS   = 5;

endpackage

// File: rtl/overlay_scheduler_rr_next_slot.sv
// Round-robin pick: next set bit of mask strictly after cur, wrapping 5->0.
// Returns cur when it is the only set bit (or the mask is empty).
module rr_next_slot
  import overlay_scheduler_pkg::*;
(
  input  logic [NUM_OV-1:0] mask,
  input  logic [2:0]        cur,
  output logic [2:0]        next
);

  logic found;
  int   j;

  always_comb begin
    next  = cur;
    found = 1'b0;
    j     = 0;
    // Offset 6 lands back on cur, covering the single-bit case.
    for (int i = 1; i <= NUM_OV; i++) begin
      j = (int'(cur) + i) % NUM_OV;
      if (!found && mask[j]) begin
        next  = 3'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/overlay_scheduler.sv
// Per-frame plotter sequencer: background, then one status overlay chosen
// round-robin among the active enables, each held for HOLD_FRAMES frames.
module overlay_scheduler
  import overlay_scheduler_pkg::*;
#(
  parameter int HOLD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [NUM_OV-1:0] enable_mask,
  input  logic              plot_done,
  output logic              plot_start,
  output logic [2:0]        sprite_sel,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_count
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cur_slot_q, cur_slot_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [NUM_OV-1:0] mask_q, mask_d;
  logic              pending_q, pending_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              arm_q, arm_d;
  logic [2:0]        next_slot;

  // Both selection points rotate over the same latched mask and slot.
  rr_next_slot u_rr (
    .mask (mask_q),
    .cur  (cur_slot_q),
    .next (next_slot)
  );

  always_comb begin
    state_d    = state_q;
    cur_slot_d = cur_slot_q;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    arm_d      = 1'b0;
    plot_start = 1'b0;
    sprite_sel = SPR_BG;
    frame_done = 1'b0;
    busy       = (state_q != WAIT_TICK);

    if (frame_tick && state_q != WAIT_TICK) begin
      if (pending_q) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      WAIT_TICK: begin
        if (frame_tick || pending_q) begin
          pending_d = 1'b0;
          state_d   = BG_START;
        end
      end
      BG_START: begin
        plot_start = 1'b1;
        mask_d     = enable_mask;
        state_d    = BG_WAIT;
      end
      BG_WAIT: begin
        if (plot_done) begin
          if (mask_q == '0) begin
            state_d = FRAME_END;
          end else begin
            if (!mask_q[cur_slot_q]) begin
              cur_slot_d = next_slot;
              hold_cnt_d = 8'd0;
            end
            state_d = OV_START;
          end
        end
      end
      OV_START: begin
        // First cycle presents the new sprite_sel to the ROM mux; the plotter
        // is kicked on the second.
        sprite_sel = 3'(cur_slot_q + 3'd1);
        if (arm_q) begin
          plot_start = 1'b1;
          state_d    = OV_WAIT;
        end else begin
          arm_d = 1'b1;
        end
      end
      OV_WAIT: begin
        sprite_sel = 3'(cur_slot_q + 3'd1);
        if (plot_done) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = 8'd0;
            cur_slot_d = next_slot;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
          state_d = FRAME_END;
        end
      end
      FRAME_END: begin
        frame_done = 1'b1;
        if (pending_q) begin
          pending_d = 1'b0;
          state_d   = BG_START;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  assign overrun_count = overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_TICK;
      cur_slot_q <= 3'd0;
      hold_cnt_q <= 8'd0;
      mask_q     <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 8'd0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_slot_q <= cur_slot_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      arm_q      <= arm_d;
    end
  end

endmodule
